// File: rtl/t07_button_strobe_gen_pkg.sv
// Shared definitions for the game's pushbutton front end and the game FSMs.
package t07_pkg;

    // One-hot button codes, bit order {BACK,LEFT,DOWN,RIGHT,UP,SELECT}
    localparam logic [5:0] NO_PRESS = 6'b000000;
    localparam logic [5:0] SELECT   = 6'b000001;
    localparam logic [5:0] UP       = 6'b000010;
    localparam logic [5:0] RIGHT    = 6'b000100;
    localparam logic [5:0] DOWN     = 6'b001000;
    localparam logic [5:0] LEFT     = 6'b010000;
    localparam logic [5:0] BACK     = 6'b100000;

    // Buttons that auto-repeat while held
    localparam logic [5:0] DIR_MASK = 6'b011110;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HELD    = 2'd1,
        REPEAT  = 2'd2,
        LOCKOUT = 2'd3
    } btn_state_t;

    // Playing-state codes shared with the maze, wire and menu FSMs
    typedef enum logic [2:0] {
        PLAY_MENU = 3'd0,
        PLAY_MAZE = 3'd1,
        PLAY_WIRE = 3'd2,
        PLAY_WIN  = 3'd3,
        PLAY_LOSE = 3'd4
    } play_state_t;

    // True when exactly one bit of v is set
    function automatic logic is_one_hot(input logic [5:0] v);
        return (v != NO_PRESS) && ((v & (v - 6'd1)) == NO_PRESS);
    endfunction

    // True when v contains a direction button
    function automatic logic is_direction(input logic [5:0] v);
        return (v & DIR_MASK) != NO_PRESS;
    endfunction

endpackage

// File: rtl/t07_button_strobe_gen_if.sv
// Button bus between the pushbutton front end and its consumers.
interface t07_button_strobe_gen_if;
    logic [5:0] btn_raw;
    logic [5:0] button;
    logic       strobe;
    logic [5:0] btn_level;

    modport master (output btn_raw, input button, input strobe, input btn_level);
    modport slave  (input btn_raw, output button, output strobe, output btn_level);
endinterface

// File: rtl/t07_button_strobe_gen_btn.sv
// Single-button 2-FF synchroniser followed by a consecutive-cycle debounce counter.
module t07_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 10000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronise the raw input and flip the level after a long enough disagreement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            cnt_r   <= CNT_ZERO;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
            if (sync2_r == level_r) begin
                cnt_r <= CNT_ZERO;
            end else if (cnt_r == CNT_LAST) begin
                level_r <= ~level_r;
                cnt_r   <= CNT_ZERO;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign btn_level = level_r;
endmodule

// File: rtl/t07_button_strobe_gen.sv
// Pushbutton front end: per-button debounce, single-press detection and auto-repeat.
module t07_button_strobe_gen
    import t07_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int REPEAT_DELAY    = 5000000,
    parameter int REPEAT_PERIOD   = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    t07_button_strobe_gen_if.slave  bus
);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
    localparam logic [RPT_W-1:0] RPT_ONE     = RPT_W'(1);
    localparam logic [RPT_W-1:0] RPT_ZERO    = RPT_W'(0);

    logic [5:0]       level_s;
    btn_state_t       state_r;
    btn_state_t       state_s;
    logic [5:0]       held_r;
    logic [5:0]       held_s;
    logic [RPT_W-1:0] rpt_cnt_r;
    logic [RPT_W-1:0] rpt_cnt_s;
    logic [RPT_W-1:0] rpt_last_s;
    logic             rpt_hit_s;
    logic             strobe_r;
    logic             strobe_s;
    logic [5:0]       button_r;
    logic [5:0]       button_s;

    for (genvar gi = 0; gi < 6; gi++) begin : g_deb
        t07_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk       (clk),
            .rst       (rst),
            .btn_raw   (bus.btn_raw[gi]),
            .btn_level (level_s[gi])
        );
    end

    // A repeat fires only for a still-held, lone direction button whose interval has elapsed
    assign rpt_last_s = (state_r == REPEAT) ? PERIOD_LAST : DELAY_LAST;
    assign rpt_hit_s  = (rpt_cnt_r == rpt_last_s) && is_direction(held_r) && (level_s == held_r);

    // State register, repeat counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            held_r    <= NO_PRESS;
            rpt_cnt_r <= RPT_ZERO;
            strobe_r  <= 1'b0;
            button_r  <= NO_PRESS;
        end else begin
            state_r   <= state_s;
            held_r    <= held_s;
            rpt_cnt_r <= rpt_cnt_s;
            strobe_r  <= strobe_s;
            button_r  <= button_s;
        end
    end

    // Next-state logic: press acceptance, repeat timing and multi-button lockout
    always_comb begin
        state_s   = state_r;
        held_s    = held_r;
        rpt_cnt_s = rpt_cnt_r;
        case (state_r)
            IDLE: begin
                if (level_s == NO_PRESS) begin
                    state_s = IDLE;
                end else if (is_one_hot(level_s)) begin
                    state_s   = HELD;
                    held_s    = level_s;
                    rpt_cnt_s = RPT_ZERO;
                end else begin
                    state_s = LOCKOUT;
                end
            end
            HELD, REPEAT: begin
                if ((level_s & ~held_r) != NO_PRESS) begin
                    state_s   = LOCKOUT;
                    held_s    = NO_PRESS;
                    rpt_cnt_s = RPT_ZERO;
                end else if (level_s == NO_PRESS) begin
                    state_s   = IDLE;
                    held_s    = NO_PRESS;
                    rpt_cnt_s = RPT_ZERO;
                end else if (rpt_hit_s) begin
                    state_s   = REPEAT;
                    rpt_cnt_s = RPT_ZERO;
                end else if (is_direction(held_r)) begin
                    rpt_cnt_s = rpt_cnt_r + RPT_ONE;
                end else begin
                    rpt_cnt_s = rpt_cnt_r;
                end
            end
            LOCKOUT: begin
                if (level_s == NO_PRESS) begin
                    state_s = IDLE;
                end else begin
                    state_s = LOCKOUT;
                end
            end
            default: begin
                state_s   = IDLE;
                held_s    = NO_PRESS;
                rpt_cnt_s = RPT_ZERO;
            end
        endcase
    end

    // Output logic: strobe with the button code on a fresh single press or a due repeat
    always_comb begin
        strobe_s = 1'b0;
        button_s = NO_PRESS;
        case (state_r)
            IDLE: begin
                if (is_one_hot(level_s)) begin
                    strobe_s = 1'b1;
                    button_s = level_s;
                end else begin
                    strobe_s = 1'b0;
                    button_s = NO_PRESS;
                end
            end
            HELD, REPEAT: begin
                if (rpt_hit_s) begin
                    strobe_s = 1'b1;
                    button_s = held_r;
                end else begin
                    strobe_s = 1'b0;
                    button_s = NO_PRESS;
                end
            end
            default: begin
                strobe_s = 1'b0;
                button_s = NO_PRESS;
            end
        endcase
    end

    assign bus.strobe    = strobe_r;
    assign bus.button    = button_r;
    assign bus.btn_level = level_s;
endmodule

// File: tb/tb_t07_button_strobe_gen.sv
// Directed self-checking bench for the pushbutton front end (small timing parameters).
module tb_t07_button_strobe_gen;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   edge_idx;
    int   viol;
    logic prev_strobe;
    int         sedge_q[$];
    logic [5:0] sbtn_q[$];
    int         exp_left[6];

    t07_button_strobe_gen_if bus ();

    t07_button_strobe_gen #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges, sampling 1 time unit after each edge and logging strobes
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            edge_idx++;
            if (bus.strobe === 1'b1) begin
                sedge_q.push_back(edge_idx);
                sbtn_q.push_back(bus.button);
            end
            if (bus.strobe === 1'b1 && prev_strobe === 1'b1) viol++;
            if (bus.strobe !== 1'b1 && bus.button !== 6'b000000) viol++;
            prev_strobe = bus.strobe;
        end
    endtask

    task automatic new_phase();
        edge_idx = -1;
        sedge_q.delete();
        sbtn_q.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        viol = 0;
        prev_strobe = 1'b0;
        edge_idx = -1;
        exp_left = '{7, 27, 35, 43, 51, 59};
        rst = 1'b1;
        bus.btn_raw = 6'b000000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_button", {26'd0, bus.button}, 32'd0);
        chk("reset_strobe", {31'd0, bus.strobe}, 32'd0);
        chk("reset_level", {26'd0, bus.btn_level}, 32'd0);
        rst = 1'b0;
        run(5);

        // 1. Clean RIGHT press held 40 cycles
        new_phase();
        bus.btn_raw = 6'b000100;
        run(6);
        chk("c1_level_before", {26'd0, bus.btn_level}, 32'd0);
        run(1);
        chk("c1_level_after", {26'd0, bus.btn_level}, 32'h04);
        chk("c1_no_early_strobe", {31'd0, bus.strobe}, 32'd0);
        run(1);
        chk("c1_strobe_edge7", {31'd0, bus.strobe}, 32'd1);
        chk("c1_button_edge7", {26'd0, bus.button}, 32'h04);
        run(32);
        bus.btn_raw = 6'b000000;
        run(20);
        chk("c1_strobe_count", sedge_q.size(), 32'd4);
        if (sedge_q.size() == 4) begin
            chk("c1_rpt1_edge", sedge_q[1], 32'd27);
            chk("c1_rpt2_edge", sedge_q[2], 32'd35);
            chk("c1_rpt3_edge", sedge_q[3], 32'd43);
        end
        chk("c1_level_released", {26'd0, bus.btn_level}, 32'd0);

        // 2. Bounce on UP shorter than the debounce window
        new_phase();
        for (int b = 0; b < 5; b++) begin
            bus.btn_raw = 6'b000010;
            for (int k = 0; k < 3; k++) begin
                run(1);
                chk("c2_level_stays_low", {26'd0, bus.btn_level}, 32'd0);
            end
            bus.btn_raw = 6'b000000;
            run(1);
        end
        run(10);
        chk("c2_no_strobe", sedge_q.size(), 32'd0);

        // 3a. LEFT held: first strobe plus five repeats
        new_phase();
        bus.btn_raw = 6'b010000;
        run(60);
        bus.btn_raw = 6'b000000;
        run(20);
        chk("c3_left_count", sedge_q.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < sedge_q.size()) begin
                chk("c3_left_edge", sedge_q[i], exp_left[i]);
                chk("c3_left_code", {26'd0, sbtn_q[i]}, 32'h10);
            end
        end

        // 3b. SELECT held for the same time never repeats
        new_phase();
        bus.btn_raw = 6'b000001;
        run(60);
        bus.btn_raw = 6'b000000;
        run(20);
        chk("c3_select_count", sedge_q.size(), 32'd1);
        if (sedge_q.size() == 1) begin
            chk("c3_select_edge", sedge_q[0], 32'd7);
            chk("c3_select_code", {26'd0, sbtn_q[0]}, 32'h01);
        end

        // 4. Two buttons together lock out until all released
        new_phase();
        bus.btn_raw = 6'b000110;
        run(20);
        bus.btn_raw = 6'b000010;
        run(20);
        chk("c4_lockout_no_strobe", sedge_q.size(), 32'd0);
        bus.btn_raw = 6'b000000;
        run(15);
        new_phase();
        bus.btn_raw = 6'b000010;
        run(15);
        bus.btn_raw = 6'b000000;
        run(15);
        chk("c4_after_release_count", sedge_q.size(), 32'd1);
        if (sedge_q.size() == 1) begin
            chk("c4_after_release_edge", sedge_q[0], 32'd7);
            chk("c4_after_release_code", {26'd0, sbtn_q[0]}, 32'h02);
        end

        // 5. RIGHT held, UP added during HELD, then a fresh DOWN press
        new_phase();
        bus.btn_raw = 6'b000100;
        run(15);
        bus.btn_raw = 6'b000110;
        run(30);
        bus.btn_raw = 6'b000000;
        run(15);
        chk("c5_right_only_once", sedge_q.size(), 32'd1);
        new_phase();
        bus.btn_raw = 6'b001000;
        run(15);
        bus.btn_raw = 6'b000000;
        run(15);
        chk("c5_down_count", sedge_q.size(), 32'd1);
        if (sedge_q.size() == 1) begin
            chk("c5_down_code", {26'd0, sbtn_q[0]}, 32'h08);
        end

        // 6. Reset pulsed mid-REPEAT with RIGHT held
        new_phase();
        bus.btn_raw = 6'b000100;
        run(28);
        chk("c6_repeat_strobe_before_rst", {31'd0, bus.strobe}, 32'd1);
        rst = 1'b1;
        #2;
        chk("c6_async_strobe", {31'd0, bus.strobe}, 32'd0);
        chk("c6_async_button", {26'd0, bus.button}, 32'd0);
        chk("c6_async_level", {26'd0, bus.btn_level}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        prev_strobe = 1'b0;
        new_phase();
        run(15);
        bus.btn_raw = 6'b000000;
        run(15);
        chk("c6_post_rst_count", sedge_q.size(), 32'd1);
        if (sedge_q.size() == 1) begin
            chk("c6_post_rst_edge", sedge_q[0], 32'd7);
            chk("c6_post_rst_code", {26'd0, sbtn_q[0]}, 32'h04);
        end

        chk("strobe_rules", viol, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
